// File: rtl/stream_out_capture.sv
// Converts the raster pixel stream into registered (X, Y, Data) records with frame geometry checks.
// Latency: 1 cycle from accepted pixel to ValidOut; STREAM_OUT_THRESH_EN binarises DataOut against ThreshIn.
// Backpressure: none; every valid pixel is consumed, non-frame pixels are dropped while idle.
module stream_out_capture #(
    parameter int DATA_W  = 8,
    parameter int COORD_W = 8,
    parameter int EXP_W   = 128,
    parameter int EXP_H   = 128,
    parameter int FCNT_W  = 16
) (
    input  logic                Clk,
    input  logic                nReset,
    input  logic [DATA_W-1:0]   PixelIn,
    input  logic                ValidIn,
    input  logic                FrameIn,
    input  logic                LineIn,
`ifdef STREAM_OUT_THRESH_EN
    input  logic [DATA_W-1:0]   ThreshIn,
`endif
    output logic [DATA_W-1:0]   DataOut,
    output logic [COORD_W-1:0]  XOut,
    output logic [COORD_W-1:0]  YOut,
    output logic                ValidOut,
    output logic                FrameDone,
    output logic [COORD_W-1:0]  MeasWidth,
    output logic [COORD_W-1:0]  MeasHeight,
    output logic [FCNT_W-1:0]   FrameCount,
    output logic                ErrLine,
    output logic                ErrFrame,
    output logic                CoordOvf
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [COORD_W-1:0] CMAX   = '1;
    localparam logic [31:0]        EXP_WU = 32'(EXP_W);
    localparam logic [31:0]        EXP_HU = 32'(EXP_H);

    state_t               state, stateNext;
    logic [COORD_W-1:0]   xCnt, yCnt, xNext, yNext;
    logic                 accept, closeLine, closeFrame, ovfSet;
    logic [COORD_W:0]     lineLen, frameLen;
    logic [DATA_W-1:0]    dataNext;

    // A saturated counter reports all-ones rather than wrapping to 2^COORD_W.
    assign lineLen  = (xCnt == CMAX) ? {1'b0, CMAX} : {1'b0, xCnt} + 1'b1;
    assign frameLen = (yCnt == CMAX) ? {1'b0, CMAX} : {1'b0, yCnt} + 1'b1;

`ifdef STREAM_OUT_THRESH_EN
    assign dataNext = (PixelIn >= ThreshIn) ? '1 : '0;
`else
    assign dataNext = PixelIn;
`endif

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        xNext      = xCnt;
        yNext      = yCnt;
        accept     = 1'b0;
        closeLine  = 1'b0;
        closeFrame = 1'b0;
        ovfSet     = 1'b0;
        if (ValidIn) begin
            case (state)
                IDLE: begin
                    if (FrameIn) begin
                        stateNext = ACTIVE;
                        accept    = 1'b1;
                        xNext     = '0;
                        yNext     = '0;
                    end
                end
                ACTIVE: begin
                    accept = 1'b1;
                    if (FrameIn) begin
                        closeLine  = 1'b1;
                        closeFrame = 1'b1;
                        xNext      = '0;
                        yNext      = '0;
                    end else if (LineIn) begin
                        closeLine = 1'b1;
                        xNext     = '0;
                        if (yCnt != CMAX) yNext = yCnt + 1'b1;
                        ovfSet    = (yNext == CMAX);
                    end else begin
                        if (xCnt != CMAX) xNext = xCnt + 1'b1;
                        ovfSet = (xNext == CMAX);
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            xCnt       <= '0;
            yCnt       <= '0;
            DataOut    <= '0;
            XOut       <= '0;
            YOut       <= '0;
            ValidOut   <= 1'b0;
            FrameDone  <= 1'b0;
            MeasWidth  <= '0;
            MeasHeight <= '0;
            FrameCount <= '0;
            ErrLine    <= 1'b0;
            ErrFrame   <= 1'b0;
            CoordOvf   <= 1'b0;
        end else begin
            xCnt      <= xNext;
            yCnt      <= yNext;
            ValidOut  <= accept;
            FrameDone <= closeFrame;
            ErrLine   <= closeLine && (32'(lineLen) != EXP_WU);
            ErrFrame  <= closeFrame && (32'(frameLen) != EXP_HU);
            if (accept) begin
                DataOut <= dataNext;
                XOut    <= xNext;
                YOut    <= yNext;
            end
            if (closeFrame) begin
                MeasWidth  <= lineLen[COORD_W-1:0];
                MeasHeight <= frameLen[COORD_W-1:0];
                FrameCount <= FrameCount + 1'b1;
            end
            // The opening pixel of a frame clears the sticky overflow.
            if (accept && FrameIn) begin
                CoordOvf <= 1'b0;
            end else if (ovfSet) begin
                CoordOvf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_out_capture.sv
// Bench for stream_out_capture: directed vector table, hand-written corner sequences and random traffic vs a reference model.
module tb_stream_out_capture;
    localparam int DATA_W  = 8;
    localparam int COORD_W = 3;
    localparam int EXP_W   = 4;
    localparam int EXP_H   = 3;
    localparam int FCNT_W  = 4;
    localparam int CMAX    = 7;

    logic              Clk = 1'b0;
    logic              nReset = 1'b0;
    logic [DATA_W-1:0] PixelIn = '0;
    logic              ValidIn = 1'b0, FrameIn = 1'b0, LineIn = 1'b0;
    logic [DATA_W-1:0] ThreshVal = 8'd128;
    logic [DATA_W-1:0] DataOut;
    logic [COORD_W-1:0] XOut, YOut, MeasWidth, MeasHeight;
    logic              ValidOut, FrameDone, ErrLine, ErrFrame, CoordOvf;
    logic [FCNT_W-1:0] FrameCount;

    stream_out_capture #(
        .DATA_W(DATA_W), .COORD_W(COORD_W), .EXP_W(EXP_W), .EXP_H(EXP_H), .FCNT_W(FCNT_W)
    ) dut (
        .Clk(Clk), .nReset(nReset), .PixelIn(PixelIn), .ValidIn(ValidIn),
        .FrameIn(FrameIn), .LineIn(LineIn),
`ifdef STREAM_OUT_THRESH_EN
        .ThreshIn(ThreshVal),
`endif
        .DataOut(DataOut), .XOut(XOut), .YOut(YOut), .ValidOut(ValidOut),
        .FrameDone(FrameDone), .MeasWidth(MeasWidth), .MeasHeight(MeasHeight),
        .FrameCount(FrameCount), .ErrLine(ErrLine), .ErrFrame(ErrFrame), .CoordOvf(CoordOvf)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model: unbounded counters clamped on output.
    bit mOpen;
    int mX, mY, mCnt;
    int eData, eX, eY, eMw, eMh;
    bit eVld, eFd, eEl, eEf, eOvf;

    typedef struct {
        bit v, f, l;
        int p;
        bit vld;
        int x, y;
        bit fd, el, ef;
    } vec_t;
    vec_t tbl[$];

    function automatic int clampc(int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mOpen = 0; mX = 0; mY = 0; mCnt = 0;
        eData = 0; eX = 0; eY = 0; eMw = 0; eMh = 0;
        eVld = 0; eFd = 0; eEl = 0; eEf = 0; eOvf = 0;
    endtask

    task automatic model_step(input bit v, input bit f, input bit l, input int p);
        eVld = 0; eFd = 0; eEl = 0; eEf = 0;
        if (!v) return;
        if (!mOpen && !f) return;
        if (mOpen && (f || l)) begin
            eEl = (clampc(mX + 1) != EXP_W);
            if (f) begin
                eFd  = 1;
                eMw  = clampc(mX + 1);
                eMh  = clampc(mY + 1);
                eEf  = (eMh != EXP_H);
                mCnt = (mCnt + 1) % (1 << FCNT_W);
            end
        end
        if (f) begin
            mOpen = 1; mX = 0; mY = 0; eOvf = 0;
        end else if (l) begin
            mX = 0; mY++;
        end else begin
            mX++;
        end
        if (mX >= CMAX || mY >= CMAX) eOvf = 1;
        eVld = 1;
        eX = clampc(mX);
        eY = clampc(mY);
`ifdef STREAM_OUT_THRESH_EN
        eData = (p >= int'(ThreshVal)) ? 255 : 0;
`else
        eData = p;
`endif
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".ValidOut"},   ValidOut,   eVld);
        chk({tag, ".DataOut"},    DataOut,    eData);
        chk({tag, ".XOut"},       XOut,       eX);
        chk({tag, ".YOut"},       YOut,       eY);
        chk({tag, ".FrameDone"},  FrameDone,  eFd);
        chk({tag, ".MeasWidth"},  MeasWidth,  eMw);
        chk({tag, ".MeasHeight"}, MeasHeight, eMh);
        chk({tag, ".FrameCount"}, FrameCount, mCnt);
        chk({tag, ".ErrLine"},    ErrLine,    eEl);
        chk({tag, ".ErrFrame"},   ErrFrame,   eEf);
        chk({tag, ".CoordOvf"},   CoordOvf,   eOvf);
    endtask

    // Drive one cycle of inputs, then sample 1ns after the capturing edge.
    task automatic step(input bit v, input bit f, input bit l, input int p);
        ValidIn = v; FrameIn = f; LineIn = l; PixelIn = p[DATA_W-1:0];
        model_step(v, f, l, p);
        @(posedge Clk);
        #1;
        ValidIn = 0; FrameIn = 0; LineIn = 0;
    endtask

    task automatic frame_3x4(input int gap, input string tag);
        for (int i = 0; i < 12; i++) begin
            step(1, i == 0, (i % 4 == 0) && (i != 0), i);
            chk($sformatf("%s[%0d].ValidOut", tag, i), ValidOut, 1);
            chk($sformatf("%s[%0d].XOut", tag, i), XOut, i % 4);
            chk($sformatf("%s[%0d].YOut", tag, i), YOut, i / 4);
            check_model($sformatf("%s[%0d]", tag, i));
            for (int g = 0; g < gap; g++) begin
                step(0, 1, 1, 99);
                chk($sformatf("%s[%0d].gapValid", tag, i), ValidOut, 0);
                chk($sformatf("%s[%0d].gapX", tag, i), XOut, i % 4);
                chk($sformatf("%s[%0d].gapY", tag, i), YOut, i / 4);
            end
        end
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 12; i++)
            tbl.push_back('{v: 1, f: i == 0, l: (i % 4 == 0) && (i != 0), p: i,
                            vld: 1, x: i % 4, y: i / 4, fd: 0, el: 0, ef: 0});
        tbl.push_back('{v: 0, f: 1, l: 0, p: 77, vld: 0, x: 3, y: 2, fd: 0, el: 0, ef: 0});
        tbl.push_back('{v: 1, f: 1, l: 0, p: 200, vld: 1, x: 0, y: 0, fd: 1, el: 0, ef: 0});

        // Reset state.
        repeat (3) @(posedge Clk);
        #1;
        check_model("reset");
        nReset = 1'b1;
        @(posedge Clk);
        #1;

        // Pixels without a frame start are dropped.
        for (int i = 0; i < 4; i++) begin
            step(1, 0, i[0], 50 + i);
            chk($sformatf("noframe[%0d].ValidOut", i), ValidOut, 0);
            chk($sformatf("noframe[%0d].FrameDone", i), FrameDone, 0);
            check_model($sformatf("noframe[%0d]", i));
        end

        // Vector table: 3x4 frame then a closing FrameIn.
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].f, tbl[i].l, tbl[i].p);
            chk($sformatf("tbl[%0d].ValidOut", i), ValidOut, tbl[i].vld);
            chk($sformatf("tbl[%0d].XOut", i), XOut, tbl[i].x);
            chk($sformatf("tbl[%0d].YOut", i), YOut, tbl[i].y);
            chk($sformatf("tbl[%0d].FrameDone", i), FrameDone, tbl[i].fd);
            chk($sformatf("tbl[%0d].ErrLine", i), ErrLine, tbl[i].el);
            chk($sformatf("tbl[%0d].ErrFrame", i), ErrFrame, tbl[i].ef);
            if (tbl[i].vld) chk($sformatf("tbl[%0d].DataOut", i), DataOut, eData);
        end
        chk("close1.MeasWidth", MeasWidth, 4);
        chk("close1.MeasHeight", MeasHeight, 3);
        chk("close1.FrameCount", FrameCount, 1);

        // Same frame with two idle cycles between pixels.
        frame_3x4(2, "gap");
        step(1, 1, 0, 1);
        chk("close2.FrameDone", FrameDone, 1);
        chk("close2.MeasWidth", MeasWidth, 4);
        chk("close2.MeasHeight", MeasHeight, 3);
        chk("close2.ErrFrame", ErrFrame, 0);
        chk("close2.FrameCount", FrameCount, 3);

        // Short middle line, then a two-line frame.
        for (int i = 1; i < 4; i++) step(1, 0, 0, i);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, i == 0, 10 + i);
            chk($sformatf("short1[%0d].ErrLine", i), ErrLine, 0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 0, i == 0, 20 + i);
            chk($sformatf("line3[%0d].ErrLine", i), ErrLine, i == 0);
            check_model($sformatf("line3[%0d]", i));
        end
        step(1, 1, 0, 30);
        chk("closeA.ErrLine", ErrLine, 0);
        chk("closeA.ErrFrame", ErrFrame, 0);
        for (int i = 1; i < 8; i++) step(1, 0, i == 4, 30 + i);
        step(1, 1, 0, 40);
        chk("closeB.ErrFrame", ErrFrame, 1);
        chk("closeB.MeasHeight", MeasHeight, 2);
        chk("closeB.ErrLine", ErrLine, 0);

        // Ten-pixel line saturates X at 7.
        for (int i = 1; i < 10; i++) begin
            step(1, 0, 0, 40 + i);
            chk($sformatf("sat[%0d].XOut", i), XOut, (i > 7) ? 7 : i);
        end
        chk("sat.CoordOvf", CoordOvf, 1);
        step(1, 1, 0, 60);
        chk("satClose.CoordOvf", CoordOvf, 0);
        chk("satClose.MeasWidth", MeasWidth, 7);
        chk("satClose.ErrLine", ErrLine, 1);
        check_model("satClose");

        // FrameIn and LineIn together behave as FrameIn.
        step(1, 0, 0, 61);
        step(1, 0, 1, 62);
        step(1, 1, 1, 63);
        chk("both.FrameDone", FrameDone, 1);
        chk("both.XOut", XOut, 0);
        chk("both.YOut", YOut, 0);
        chk("both.MeasHeight", MeasHeight, 2);
        check_model("both");

        // Asynchronous reset mid-frame discards the frame.
        step(1, 0, 0, 64);
        #2 nReset = 1'b0;
        #1;
        model_reset();
        check_model("arst");
        @(posedge Clk);
        #1 nReset = 1'b1;
        step(1, 1, 0, 70);
        chk("postrst.ValidOut", ValidOut, 1);
        chk("postrst.FrameDone", FrameDone, 0);
        chk("postrst.FrameCount", FrameCount, 0);
        check_model("postrst");

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            bit v, f, l;
            v = ($urandom_range(99) < 70);
            f = ($urandom_range(99) < 4);
            l = ($urandom_range(99) < 20);
            ThreshVal = 8'($urandom_range(255));
            step(v, f, l, $urandom_range(255));
            check_model($sformatf("rnd[%0d]", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
